// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings and helpers for the control pipeline and its hazard unit.
package ctrl_pipe_pkg;

  localparam logic [4:0] REG_RA  = 5'd31;   // link register written by JAL

  // forward-select encodings for the EX operand muxes
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // write-back data select encodings
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC   = 2'b10;

  // control word held in ID/EX
  typedef struct packed {
    logic       regWr;
    logic       memRead;
    logic       DMWr;
    logic [1:0] be;
    logic [4:0] ALUOp;
    logic [1:0] ASel;
    logic       BSel;
    logic [1:0] wcs;
  } ex_ctrl_t;

  // subset still needed from MEM onward
  typedef struct packed {
    logic       regWr;
    logic       memRead;
    logic       DMWr;
    logic [1:0] be;
    logic [1:0] wcs;
  } mem_ctrl_t;

  // true when the ID instruction reads x; register 0 never matches
  function automatic logic src_match(input logic [4:0] x, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rs,
                                     input logic use_rt);
    return (x != 5'd0) && ((use_rs && x == rs) || (use_rt && x == rt));
  endfunction

  // EX operand source: MEM result wins over WB result
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic mem_wr, input logic [4:0] mem_dst,
                                         input logic wb_wr,  input logic [4:0] wb_dst);
    if (mem_wr && mem_dst != 5'd0 && mem_dst == src) return FWD_MEM;
    if (wb_wr  && wb_dst  != 5'd0 && wb_dst  == src) return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_fwd.sv
// Combinational stall / flush / forward-select logic.
module hazard_fwd
  import ctrl_pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_cmp,
  input  logic       id_redirect,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_dst,
  input  logic       ex_regWr,
  input  logic       ex_memRead,
  input  logic [4:0] mem_dst,
  input  logic       mem_regWr,
  input  logic       mem_memRead,
  input  logic [4:0] wb_dst,
  input  logic       wb_regWr,
  output logic       stall,
  output logic       ifidFlush,
  output logic [1:0] ex_fwdA,
  output logic [1:0] ex_fwdB,
  output logic       id_fwdA,
  output logic       id_fwdB
);

  logic hit_ex, hit_mem;
  logic load_use, br_ex, br_mem_ld;
  logic mem_alu_ok;

  // stall terms, flush gating and all forwarding selects
  always_comb begin
    hit_ex     = src_match(ex_dst,  id_rs, id_rt, id_use_rs, id_use_rt);
    hit_mem    = src_match(mem_dst, id_rs, id_rt, id_use_rs, id_use_rt);
    load_use   = ex_memRead && hit_ex;
    br_ex      = id_cmp && ex_regWr && hit_ex;
    br_mem_ld  = id_cmp && mem_memRead && hit_mem;
    stall      = load_use || br_ex || br_mem_ld;
    // a stalled redirect is simply retried next cycle
    ifidFlush  = id_redirect && !stall;
    ex_fwdA    = fwd_sel(ex_rs, mem_regWr, mem_dst, wb_regWr, wb_dst);
    ex_fwdB    = fwd_sel(ex_rt, mem_regWr, mem_dst, wb_regWr, wb_dst);
    // only an ALU result is ready in EX/MEM; load data is not
    mem_alu_ok = mem_regWr && !mem_memRead && (mem_dst != 5'd0);
    id_fwdA    = mem_alu_ok && (mem_dst == id_rs);
    id_fwdB    = mem_alu_ok && (mem_dst == id_rt);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control registers plus hazard/forward unit.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter logic [4:0] REG_RA = ctrl_pipe_pkg::REG_RA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_cmp,
  input  logic       id_regWr,
  input  logic       id_memRead,
  input  logic       id_DMWr,
  input  logic [1:0] id_be,
  input  logic [4:0] id_ALUOp,
  input  logic [1:0] id_ASel,
  input  logic       id_BSel,
  input  logic       id_WriteDstSel,
  input  logic [1:0] id_WriteContentSel,
  input  logic       id_redirect,
  output logic       pcWr,
  output logic       ifidWr,
  output logic       ifidFlush,
  output logic [4:0] ex_ALUOp,
  output logic [1:0] ex_ASel,
  output logic       ex_BSel,
  output logic [1:0] ex_fwdA,
  output logic [1:0] ex_fwdB,
  output logic       id_fwdA,
  output logic       id_fwdB,
  output logic       mem_DMWr,
  output logic [1:0] mem_be,
  output logic       wb_regWr,
  output logic [4:0] wb_dst,
  output logic [1:0] wb_WriteContentSel
);

  ex_ctrl_t  id_c, ex_c;
  mem_ctrl_t mem_c;
  logic [4:0] id_dst, ex_dst, ex_rs, ex_rt, mem_dst;
  logic       stall;

  assign id_c = '{regWr: id_regWr, memRead: id_memRead, DMWr: id_DMWr, be: id_be,
                  ALUOp: id_ALUOp, ASel: id_ASel, BSel: id_BSel, wcs: id_WriteContentSel};

  // destination register: JAL links to RA, else rd or rt
  always_comb begin
    id_dst = id_rt;
    if (id_WriteContentSel == WB_PC) id_dst = REG_RA;
    else if (id_WriteDstSel)         id_dst = id_rd;
  end

  // ID/EX: a stall inserts an all-zero bubble
  always_ff @(posedge clk) begin
    if (rst || stall) begin
      ex_c   <= '0;
      ex_dst <= '0;
      ex_rs  <= '0;
      ex_rt  <= '0;
    end else begin
      ex_c   <= id_c;
      ex_dst <= id_dst;
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
    end
  end

  // EX/MEM: always advances
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_c   <= '0;
      mem_dst <= '0;
    end else begin
      mem_c   <= '{regWr: ex_c.regWr, memRead: ex_c.memRead, DMWr: ex_c.DMWr,
                   be: ex_c.be, wcs: ex_c.wcs};
      mem_dst <= ex_dst;
    end
  end

  // MEM/WB: always advances
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_regWr           <= 1'b0;
      wb_dst             <= '0;
      wb_WriteContentSel <= '0;
    end else begin
      wb_regWr           <= mem_c.regWr;
      wb_dst             <= mem_dst;
      wb_WriteContentSel <= mem_c.wcs;
    end
  end

  hazard_fwd u_hz (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_cmp      (id_cmp),
    .id_redirect (id_redirect),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_dst      (ex_dst),
    .ex_regWr    (ex_c.regWr),
    .ex_memRead  (ex_c.memRead),
    .mem_dst     (mem_dst),
    .mem_regWr   (mem_c.regWr),
    .mem_memRead (mem_c.memRead),
    .wb_dst      (wb_dst),
    .wb_regWr    (wb_regWr),
    .stall       (stall),
    .ifidFlush   (ifidFlush),
    .ex_fwdA     (ex_fwdA),
    .ex_fwdB     (ex_fwdB),
    .id_fwdA     (id_fwdA),
    .id_fwdB     (id_fwdB)
  );

  assign pcWr     = !stall;
  assign ifidWr   = !stall;
  assign ex_ALUOp = ex_c.ALUOp;
  assign ex_ASel  = ex_c.ASel;
  assign ex_BSel  = ex_c.BSel;
  assign mem_DMWr = mem_c.DMWr;
  assign mem_be   = mem_c.be;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Bench for ctrl_pipe: in-flight instruction model plus directed scenarios.
module tb_ctrl_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs, rt, rd;
    logic       use_rs, use_rt, cmp, regWr, memRead, DMWr;
    logic [1:0] be;
    logic [4:0] ALUOp;
    logic [1:0] ASel;
    logic       BSel, WriteDstSel;
    logic [1:0] wcs;
    logic       redirect;
  } id_t;

  // one in-flight instruction as the model sees it
  typedef struct packed {
    logic       regWr, memRead, DMWr;
    logic [1:0] be;
    logic [4:0] ALUOp;
    logic [1:0] ASel;
    logic       BSel;
    logic [1:0] wcs;
    logic [4:0] dst, rs, rt;
  } rec_t;

  id_t  din;
  rec_t st[3];          // 0 = EX, 1 = MEM, 2 = WB
  logic chk_en;
  int   tests = 0;
  int   fails = 0;

  logic       pcWr, ifidWr, ifidFlush, ex_BSel, id_fwdA, id_fwdB, mem_DMWr, wb_regWr;
  logic [4:0] ex_ALUOp, wb_dst;
  logic [1:0] ex_ASel, ex_fwdA, ex_fwdB, mem_be, wb_WriteContentSel;

  ctrl_pipe dut (
    .clk(clk), .rst(rst),
    .id_rs(din.rs), .id_rt(din.rt), .id_rd(din.rd),
    .id_use_rs(din.use_rs), .id_use_rt(din.use_rt), .id_cmp(din.cmp),
    .id_regWr(din.regWr), .id_memRead(din.memRead), .id_DMWr(din.DMWr),
    .id_be(din.be), .id_ALUOp(din.ALUOp), .id_ASel(din.ASel), .id_BSel(din.BSel),
    .id_WriteDstSel(din.WriteDstSel), .id_WriteContentSel(din.wcs),
    .id_redirect(din.redirect),
    .pcWr(pcWr), .ifidWr(ifidWr), .ifidFlush(ifidFlush),
    .ex_ALUOp(ex_ALUOp), .ex_ASel(ex_ASel), .ex_BSel(ex_BSel),
    .ex_fwdA(ex_fwdA), .ex_fwdB(ex_fwdB), .id_fwdA(id_fwdA), .id_fwdB(id_fwdB),
    .mem_DMWr(mem_DMWr), .mem_be(mem_be),
    .wb_regWr(wb_regWr), .wb_dst(wb_dst), .wb_WriteContentSel(wb_WriteContentSel)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [4:0] m_dst(input id_t d);
    if (d.wcs == 2'b10) return 5'd31;
    return d.WriteDstSel ? d.rd : d.rt;
  endfunction

  function automatic logic reads(input logic [4:0] x);
    return x != 5'd0 && ((din.use_rs && x == din.rs) || (din.use_rt && x == din.rt));
  endfunction

  // a needed value is not ready: EX loads are late for everyone, EX results
  // are late for the ID comparator, MEM loads are late for the comparator
  function automatic logic m_stall();
    logic s = 1'b0;
    for (int k = 0; k < 2; k++)
      if (reads(st[k].dst)) begin
        if (k == 0 && st[k].memRead)             s = 1'b1;
        if (k == 0 && din.cmp && st[k].regWr)    s = 1'b1;
        if (k == 1 && din.cmp && st[k].memRead)  s = 1'b1;
      end
    return s;
  endfunction

  // newest producer of a register among MEM, WB supplies the EX operand
  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (r == 5'd0) return 2'd0;
    for (int k = 1; k < 3; k++)
      if (st[k].regWr && st[k].dst == r) return (k == 1) ? 2'd1 : 2'd2;
    return 2'd0;
  endfunction

  function automatic logic m_idfwd(input logic [4:0] r);
    return st[1].regWr && !st[1].memRead && st[1].dst != 5'd0 && st[1].dst == r;
  endfunction

  task automatic model_update();
    rec_t n = '0;
    if (rst) begin
      for (int k = 0; k < 3; k++) st[k] = '0;
    end else begin
      if (!m_stall()) begin
        n.regWr = din.regWr; n.memRead = din.memRead; n.DMWr = din.DMWr;
        n.be = din.be; n.ALUOp = din.ALUOp; n.ASel = din.ASel; n.BSel = din.BSel;
        n.wcs = din.wcs; n.dst = m_dst(din); n.rs = din.rs; n.rt = din.rt;
      end
      st[2] = st[1]; st[1] = st[0]; st[0] = n;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    logic s;
    if (chk_en) begin
      s = m_stall();
      chk("pcWr", pcWr, !s);
      chk("ifidWr", ifidWr, !s);
      chk("ifidFlush", ifidFlush, din.redirect && !s);
      chk("ex_ALUOp", ex_ALUOp, st[0].ALUOp);
      chk("ex_ASel", ex_ASel, st[0].ASel);
      chk("ex_BSel", ex_BSel, st[0].BSel);
      chk("ex_fwdA", ex_fwdA, m_fwd(st[0].rs));
      chk("ex_fwdB", ex_fwdB, m_fwd(st[0].rt));
      chk("id_fwdA", id_fwdA, m_idfwd(din.rs));
      chk("id_fwdB", id_fwdB, m_idfwd(din.rt));
      chk("mem_DMWr", mem_DMWr, st[1].DMWr);
      chk("mem_be", mem_be, st[1].be);
      chk("wb_regWr", wb_regWr, st[2].regWr);
      chk("wb_dst", wb_dst, st[2].dst);
      chk("wb_wcs", wb_WriteContentSel, st[2].wcs);
    end
  end

  task automatic rand_din();
    din.rs = 5'($urandom_range(0, 7));
    din.rt = 5'($urandom_range(0, 7));
    din.rd = 5'($urandom_range(0, 7));
    din.use_rs = 1'($urandom_range(0, 1));
    din.use_rt = 1'($urandom_range(0, 1));
    din.cmp = ($urandom_range(0, 3) == 0);
    din.regWr = 1'($urandom_range(0, 1));
    din.memRead = ($urandom_range(0, 3) == 0);
    din.DMWr = ($urandom_range(0, 3) == 0);
    din.be = 2'($urandom_range(0, 3));
    din.ALUOp = 5'($urandom_range(0, 31));
    din.ASel = 2'($urandom_range(0, 3));
    din.BSel = 1'($urandom_range(0, 1));
    din.WriteDstSel = 1'($urandom_range(0, 1));
    din.wcs = 2'($urandom_range(0, 2));
    din.redirect = ($urandom_range(0, 3) == 0);
  endtask

  task automatic drain();
    din = '0;
    repeat (3) step();
  endtask

  task automatic dbl(input logic [4:0] d, input logic [1:0] exp, input string nm);
    drain();
    din = '0; din.rd = d; din.WriteDstSel = 1'b1; din.regWr = 1'b1;
    step(); step();
    din = '0; din.rs = d; din.rt = d; din.use_rs = 1'b1; din.use_rt = 1'b1;
    step();
    din = '0;
    @(negedge clk);
    chk({nm, "_A"}, ex_fwdA, exp);
    chk({nm, "_B"}, ex_fwdB, exp);
  endtask

  initial begin
    din = '0; rst = 1'b1; chk_en = 1'b0;
    for (int k = 0; k < 3; k++) st[k] = '0;
    rand_din(); step();
    chk_en = 1'b1;
    rand_din(); step();
    @(negedge clk);
    chk("rst_pcWr", pcWr, 1);
    chk("rst_ifidWr", ifidWr, 1);
    chk("rst_wb_regWr", wb_regWr, 0);
    chk("rst_mem_DMWr", mem_DMWr, 0);
    chk("rst_fwd", {ex_fwdA, ex_fwdB, id_fwdA, id_fwdB}, 0);
    chk("rst_wb_dst", wb_dst, 0);
    rst = 1'b0;
    drain();

    // load-use: lw $8 then add reading $8
    din = '0; din.rt = 5'd8; din.use_rs = 1'b1; din.regWr = 1'b1;
    din.memRead = 1'b1; din.wcs = 2'b01;
    step();
    din = '0; din.rs = 5'd8; din.rd = 5'd9; din.use_rs = 1'b1; din.use_rt = 1'b1;
    din.regWr = 1'b1; din.WriteDstSel = 1'b1; din.ALUOp = 5'd2;
    @(negedge clk);
    chk("lu_pcWr", pcWr, 0);
    chk("lu_ifidWr", ifidWr, 0);
    step();
    @(negedge clk);
    chk("lu_release", pcWr, 1);
    chk("lu_bubble_ex", ex_ALUOp, 0);
    step();
    din = '0;
    @(negedge clk);
    chk("lu_fwdA", ex_fwdA, 2'b10);
    chk("lu_wb_dst", wb_dst, 8);
    step();
    @(negedge clk);
    chk("lu_bubble_wb", wb_regWr, 0);

    // MEM beats WB; register 0 never forwards
    dbl(5'd3, 2'b01, "dbl3");
    dbl(5'd0, 2'b00, "dbl0");

    // branch after ALU write of $5, with redirect held back by the stall
    drain();
    din = '0; din.rd = 5'd5; din.WriteDstSel = 1'b1; din.regWr = 1'b1; din.ALUOp = 5'd1;
    step();
    din = '0; din.rs = 5'd5; din.use_rs = 1'b1; din.use_rt = 1'b1; din.cmp = 1'b1;
    din.redirect = 1'b1;
    @(negedge clk);
    chk("bex_pcWr", pcWr, 0);
    chk("bex_flush_held", ifidFlush, 0);
    step();
    @(negedge clk);
    chk("bex_pcWr_rel", pcWr, 1);
    chk("bex_flush", ifidFlush, 1);
    chk("bex_idfwdA", id_fwdA, 1);
    step();

    // branch after lw $5: two-cycle stall, no ID forward afterwards
    drain();
    din = '0; din.rt = 5'd5; din.use_rs = 1'b1; din.regWr = 1'b1; din.memRead = 1'b1;
    din.wcs = 2'b01;
    step();
    din = '0; din.rs = 5'd5; din.use_rs = 1'b1; din.use_rt = 1'b1; din.cmp = 1'b1;
    @(negedge clk); chk("bld_stall1", pcWr, 0);
    step();
    @(negedge clk); chk("bld_stall2", pcWr, 0);
    step();
    @(negedge clk);
    chk("bld_release", pcWr, 1);
    chk("bld_idfwdA", id_fwdA, 0);
    step();

    // redirect with no hazard
    drain();
    din = '0; din.redirect = 1'b1;
    @(negedge clk);
    chk("jmp_flush", ifidFlush, 1);
    chk("jmp_pcWr", pcWr, 1);
    step();

    // JAL writes $31 with PC data
    drain();
    din = '0; din.wcs = 2'b10; din.regWr = 1'b1; din.rt = 5'd7; din.rd = 5'd9;
    step();
    din = '0;
    step(); step();
    @(negedge clk);
    chk("jal_dst", wb_dst, 31);
    chk("jal_wcs", wb_WriteContentSel, 2'b10);
    chk("jal_regWr", wb_regWr, 1);

    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      rand_din();
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
